// File: rtl/dram_pkg.sv
// dram_pkg: command encodings, scheduler states and width helpers.
// S_REFRESH exists only when DRAM_SCHED_REFRESH_EN is defined.
package dram_pkg;

   localparam logic [1:0] CMD_PRE = 2'b00;
   localparam logic [1:0] CMD_ACT = 2'b01;
   localparam logic [1:0] CMD_RD  = 2'b10;
   localparam logic [1:0] CMD_WR  = 2'b11;

   localparam int DEF_BANKS = 8;
   localparam int DEF_ROWS  = 128;
   localparam int DEF_COLS  = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO
`ifdef DRAM_SCHED_REFRESH_EN
      ,
      S_REFRESH
`endif
   } sched_state_e;

   // Index width for a power-of-two count, never narrower than 1 bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_BANK_W = idx_w(DEF_BANKS);
   localparam int DEF_ROW_W  = idx_w(DEF_ROWS);
   localparam int DEF_COL_W  = idx_w(DEF_COLS);

endpackage

// File: rtl/dram_open_row_table.sv
// dram_open_row_table: per-bank open flag and open row index.
// Combinational lookup port, single registered update port.
module dram_open_row_table
   import dram_pkg::*;
#(
   parameter int NUM_OF_BANKS = DEF_BANKS,
   parameter int NUM_OF_ROWS  = DEF_ROWS,
   localparam int BW = idx_w(NUM_OF_BANKS),
   localparam int RW = idx_w(NUM_OF_ROWS)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic [BW-1:0] lk_bank,
   output logic          lk_open,
   output logic [RW-1:0] lk_row,
   input  logic          upd_en,
   input  logic          upd_set,
   input  logic [BW-1:0] upd_bank,
   input  logic [RW-1:0] upd_row
);

   logic [NUM_OF_BANKS-1:0] open_q;
   logic [RW-1:0]           row_q [NUM_OF_BANKS];

   // ACT opens a bank on a row, PRE closes it; reset closes all.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         open_q <= '0;
         for (int i = 0; i < NUM_OF_BANKS; i++)
            row_q[i] <= '0;
      end else if (upd_en) begin
         open_q[upd_bank] <= upd_set;
         if (upd_set)
            row_q[upd_bank] <= upd_row;
      end
   end

   assign lk_open = open_q[lk_bank];
   assign lk_row  = row_q[lk_bank];

endmodule

// File: rtl/dram_bank_sched.sv
// dram_bank_sched: PRE/ACT/RD/WR scheduler over a 4-phase req/ack link.
// Define DRAM_SCHED_REFRESH_EN for the periodic close-all sweep.
module dram_bank_sched
   import dram_pkg::*;
#(
   parameter int NUM_OF_BANKS   = DEF_BANKS,
   parameter int NUM_OF_ROWS    = DEF_ROWS,
   parameter int NUM_OF_COLS    = DEF_COLS,
   parameter int REFRESH_PERIOD = 1024,
   localparam int BW = idx_w(NUM_OF_BANKS),
   localparam int RW = idx_w(NUM_OF_ROWS),
   localparam int CW = idx_w(NUM_OF_COLS)
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_rw,
   input  logic [BW-1:0]           req_bank,
   input  logic [RW-1:0]           req_row,
   input  logic [CW-1:0]           req_col,
   output logic                    cmd_req,
   input  logic                    cmd_ack,
   output logic [1:0]              cmd,
   output logic [NUM_OF_BANKS-1:0] bank_sel,
   output logic [NUM_OF_ROWS-1:0]  row_sel,
   output logic [NUM_OF_COLS-1:0]  col_sel,
   output logic                    bank_rw,
   output logic                    buf_rw,
   output logic                    done,
   output logic                    row_hit
);

   sched_state_e  state, state_nx;
   logic [BW-1:0] bank_q;
   logic [RW-1:0] row_q, pre_row_q;
   logic [CW-1:0] col_q;
   logic [1:0]    cmd_q, plan_cmd;
   logic          rw_q, hit_q, cmd_req_q, ready_q;
   logic          done_q, hit_pulse_q;
   logic          plan_hit, accept, ack_hi, ack_lo;
   logic          more, sweep, pend;
   logic [BW-1:0] lk_bank;
   logic          lk_open;
   logic [RW-1:0] lk_row;
   logic          upd_en;

   dram_open_row_table #(
      .NUM_OF_BANKS (NUM_OF_BANKS),
      .NUM_OF_ROWS  (NUM_OF_ROWS)
   ) u_tbl (
      .clk      (clk),
      .rst_b    (rst_b),
      .lk_bank  (lk_bank),
      .lk_open  (lk_open),
      .lk_row   (lk_row),
      .upd_en   (upd_en),
      .upd_set  (cmd_q == CMD_ACT),
      .upd_bank (bank_q),
      .upd_row  (row_q)
   );

`ifdef DRAM_SCHED_REFRESH_EN
   localparam int RCW = idx_w(REFRESH_PERIOD);

   logic [RCW-1:0] ref_cnt;
   logic [BW-1:0]  ref_idx;
   logic           pend_q, refr_q, wrap, ref_last;

   assign wrap     = (ref_cnt == RCW'(REFRESH_PERIOD - 1));
   assign ref_last = (ref_idx == BW'(NUM_OF_BANKS - 1));
   assign pend     = pend_q;
   assign sweep    = refr_q;
   assign lk_bank  = (state == S_REFRESH) ? ref_idx : req_bank;

   // Refresh timer, pending flag and the ascending bank sweep pointer.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ref_cnt <= '0;
         pend_q  <= 1'b0;
         refr_q  <= 1'b0;
         ref_idx <= '0;
      end else begin
         ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
         if (wrap)
            pend_q <= 1'b1;
         else if (state == S_REFRESH && state_nx == S_IDLE)
            pend_q <= 1'b0;
         if (state == S_IDLE && state_nx == S_REFRESH) begin
            refr_q  <= 1'b1;
            ref_idx <= '0;
         end else if (state == S_REFRESH) begin
            if (state_nx == S_IDLE)
               refr_q <= 1'b0;
            else if (!lk_open)
               ref_idx <= ref_idx + 1'b1;
         end
      end
   end
`else
   assign pend    = 1'b0;
   assign sweep   = 1'b0;
   assign lk_bank = req_bank;
`endif

   assign req_ready = ready_q && !pend;
   assign accept    = (state == S_IDLE) && req_valid && req_ready;
   assign ack_hi    = (state == S_WAIT_HI) && cmd_ack;
   assign ack_lo    = (state == S_WAIT_LO) && !cmd_ack;
   assign more      = !sweep && (cmd_q == CMD_PRE || cmd_q == CMD_ACT);
   assign upd_en    = ack_hi && (cmd_q == CMD_PRE || cmd_q == CMD_ACT);

   // First command of the plan from the looked-up bank state.
   always_comb begin
      plan_cmd = req_rw ? CMD_WR : CMD_RD;
      plan_hit = 1'b0;
      unique case (1'b1)
         !lk_open:                      plan_cmd = CMD_ACT;
         lk_open && lk_row != req_row:  plan_cmd = CMD_PRE;
         lk_open && lk_row == req_row:  plan_hit = 1'b1;
      endcase
   end

   // Next state of the handshake sequencer.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
`ifdef DRAM_SCHED_REFRESH_EN
            if (pend_q)
               state_nx = S_REFRESH;
            else
`endif
            if (accept)
               state_nx = S_ISSUE;
         end
         S_ISSUE:   state_nx = S_WAIT_HI;
         S_WAIT_HI: if (cmd_ack) state_nx = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!cmd_ack) begin
               state_nx = more ? S_ISSUE : S_IDLE;
`ifdef DRAM_SCHED_REFRESH_EN
               if (refr_q)
                  state_nx = S_REFRESH;
`endif
            end
         end
`ifdef DRAM_SCHED_REFRESH_EN
         S_REFRESH: begin
            if (lk_open)
               state_nx = S_ISSUE;
            else if (ref_last)
               state_nx = S_IDLE;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // State, request capture, command sequencing and completion pulses.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state       <= S_IDLE;
         bank_q      <= '0;
         row_q       <= '0;
         pre_row_q   <= '0;
         col_q       <= '0;
         rw_q        <= 1'b0;
         hit_q       <= 1'b0;
         cmd_q       <= CMD_PRE;
         cmd_req_q   <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         hit_pulse_q <= 1'b0;
      end else begin
         state       <= state_nx;
         ready_q     <= (state_nx == S_IDLE);
         done_q      <= ack_lo && !more && !sweep;
         hit_pulse_q <= ack_lo && !more && !sweep && hit_q;
         if (accept) begin
            bank_q    <= req_bank;
            row_q     <= req_row;
            pre_row_q <= lk_row;
            col_q     <= req_col;
            rw_q      <= req_rw;
            cmd_q     <= plan_cmd;
            hit_q     <= plan_hit;
         end
`ifdef DRAM_SCHED_REFRESH_EN
         if (state == S_REFRESH && lk_open) begin
            bank_q    <= ref_idx;
            pre_row_q <= lk_row;
            cmd_q     <= CMD_PRE;
         end
`endif
         if (ack_lo && more)
            cmd_q <= (cmd_q == CMD_PRE) ? CMD_ACT : (rw_q ? CMD_WR : CMD_RD);
         if (ack_hi)
            cmd_req_q <= 1'b0;
         else if (state == S_ISSUE || (ack_lo && more))
            cmd_req_q <= 1'b1;
      end
   end

   assign cmd_req  = cmd_req_q;
   assign cmd      = cmd_req_q ? cmd_q : CMD_PRE;
   assign bank_sel = cmd_req_q ? (NUM_OF_BANKS'(1) << bank_q) : '0;
   assign row_sel  = !cmd_req_q          ? '0 :
                     (cmd_q == CMD_PRE)  ? (NUM_OF_ROWS'(1) << pre_row_q) :
                     (cmd_q == CMD_ACT)  ? (NUM_OF_ROWS'(1) << row_q) : '0;
   assign col_sel  = (cmd_req_q && cmd_q[1]) ? (NUM_OF_COLS'(1) << col_q) : '0;
   assign bank_rw  = cmd_req_q && (cmd_q == CMD_PRE);
   assign buf_rw   = cmd_req_q && (cmd_q == CMD_WR);
   assign done     = done_q;
   assign row_hit  = hit_pulse_q;

endmodule

// File: doc/dram_bank_sched.md
# dram_bank_sched

Command scheduler between the L2 request path and the DRAM command interface. Accepts one decoded request at a time (bank/row/col plus read/write), tracks the open row of every bank, and issues the minimal sequence of PRECHARGE / ACTIVATE / READ / WRITE commands over the four-phase `cmd_req`/`cmd_ack` handshake. Drives the one-hot `bank_sel`/`row_sel`/`col_sel` and the `bank_rw`/`buf_rw` strobes consumed by the DRAM model.

## Interface
- `NUM_OF_BANKS`, default 8: number of banks. Power of two.
- `NUM_OF_ROWS`, default 128: rows per bank. Power of two.
- `NUM_OF_COLS`, default 8: columns per row. Power of two.
- `REFRESH_PERIOD`, default 1024: cycles between forced close-all sweeps. Used only with the macro.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_b` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: scheduler can accept a request.
- `req_rw` in 1: 1 = write, 0 = read.
- `req_bank` in clog2(NUM_OF_BANKS): target bank.
- `req_row` in clog2(NUM_OF_ROWS): target row.
- `req_col` in clog2(NUM_OF_COLS): target column.
- `cmd_req` out 1: command valid; four-phase handshake.
- `cmd_ack` in 1: command acknowledge.
- `cmd` out 2: `00` PRE, `01` ACT, `10` RD, `11` WR.
- `bank_sel` out NUM_OF_BANKS: one-hot bank.
- `row_sel` out NUM_OF_ROWS: one-hot row; zero on RD/WR.
- `col_sel` out NUM_OF_COLS: one-hot column; zero on PRE/ACT.
- `bank_rw` out 1: 1 during PRE (buffer written back to bank), else 0.
- `buf_rw` out 1: 1 during WR (data into row buffer), else 0.
- `done` out 1: one-cycle pulse on request completion.
- `row_hit` out 1: one-cycle pulse, coincident with `done`, if the request needed no PRE/ACT.

## Operation
- Open-row table: per bank, an `open` bit and row index. After reset, all banks are closed.
- A request is accepted on a rising edge with `req_valid && req_ready`. `req_ready` is high only in IDLE. Request fields are registered at acceptance.
- Command plan, decided at acceptance:
  - bank open, same row: RD or WR (hit).
  - bank closed: ACT, then RD/WR.
  - bank open, different row: PRE, ACT, then RD/WR.
- Table update: PRE clears `open`. ACT sets `open` and the row. Each update takes effect on the cycle its ack-high is sampled.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, and REFRESH (macro only).
  - IDLE → ISSUE on accept.
  - ISSUE drives `cmd_req`=1 and goes to WAIT_HI.
  - WAIT_HI holds until `cmd_ack`=1 is sampled, then drops `cmd_req` and goes to WAIT_LO.
  - WAIT_LO holds until `cmd_ack`=0 is sampled, then goes to ISSUE (more commands) or IDLE (plan finished; pulse `done`).
- `cmd`, the selects and the strobes are stable for the whole interval `cmd_req`=1, and are zero whenever `cmd_req`=0.
- An early `cmd_ack` (high while in ISSUE or IDLE) is ignored. The handshake must observe low→high→low for every command.

## Timing
- Reset values: `req_ready`=0 while `rst_b`=0 and 1 from the first edge after release. All other outputs are 0. State is IDLE and the table is cleared.
- Reset asserted mid-handshake aborts immediately. The in-flight request is dropped and no `done` is issued.
- `cmd_req` rises one cycle after acceptance.
- Per command: `cmd_req` falls the cycle after ack-high is sampled. The next `cmd_req` rises the cycle after ack-low is sampled.
- `done`/`row_hit` pulse in the cycle after the final ack-low is sampled. `req_ready` is 1 in that same cycle, so back-to-back requests are allowed.
- Minimum latency, acceptance to `done`, with a responder that acks one cycle after each edge: hit 5 cycles, closed 9, conflict 13.

## Configuration
- `DRAM_SCHED_REFRESH_EN` defined:
  - A free-running counter counts from 0 to REFRESH_PERIOD-1 and raises a pending flag at wrap.
  - When the flag is set, IDLE enters REFRESH instead of accepting; `req_ready` is 0.
  - REFRESH issues PRE to each open bank in ascending bank order using the normal handshake, then clears the flag and returns to IDLE.
  - An in-flight request always completes before REFRESH.
  - No `done` pulse is issued for REFRESH.
- Undefined: no counter, no REFRESH state, and rows stay open indefinitely.

## Structure
- Shared package `dram_pkg` holds:
  - the `cmd` encoding constants `CMD_PRE`, `CMD_ACT`, `CMD_RD`, `CMD_WR`;
  - the scheduler state enum;
  - the width helper localparams.
- Sub-module `dram_open_row_table` holds per-bank open bit and row, with a lookup port (bank → open, row) and an update port (set/clear).

## Test plan
- After reset, read bank 2 row 5 col 3 → ACT (`bank_sel`=8'h04, `row_sel` bit 5), then RD (`col_sel`=8'h08), `done`, `row_hit`=0.
- Then write bank 2 row 5 col 1 → single WR with `buf_rw`=1, `done` with `row_hit`=1.
- Then read bank 2 row 9 → PRE with `bank_rw`=1, ACT on row 9, RD; 3 handshakes; `row_hit`=0.
- Hold `cmd_ack`=1 for 4 cycles after the ack response, then drop it → `cmd_req` stays 0, and the next command is issued only after ack-low is sampled.
- Assert `rst_b`=0 during the ACT of a conflict sequence → all outputs are 0 asynchronously and no `done`; then a read of the same bank and row yields ACT+RD (table cleared).
- With `DRAM_SCHED_REFRESH_EN`, REFRESH_PERIOD=64, banks 1 and 6 open → at the wrap, PRE to bank 1, then PRE to bank 6, with `req_ready`=0 throughout; the next access to bank 1 yields ACT+RD.
